// File: rtl/fft_cap_pkg.sv
// Shared sizing, FSM state type and magnitude helpers for the FFT spectrum capture block.
package fft_cap_pkg;

    localparam int FFT_LEN = 4096;
    localparam int DW      = 24;
    localparam int MAG_W   = DW + 1;
    localparam int AW      = $clog2(FFT_LEN / 2);
    localparam int CW      = AW + 1;

    typedef enum logic {
        IDLE,
        CAPTURE
    } cap_state_t;

    // Unsigned absolute value; the most negative input maps to 2^(DW-1) without wrapping.
    function automatic logic [DW-1:0] abs_u(input logic [DW-1:0] x);
        return x[DW-1] ? ((~x) + DW'(1)) : x;
    endfunction

    function automatic logic [MAG_W-1:0] l1_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/spectrum_bin_ram.sv
// Simple dual-port bin RAM: one write port, one registered read port.
module spectrum_bin_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 25
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_spectrum_capture.sv
// Avalon-ST sink for FFT output: frame checking, L1 magnitude, double-buffered bin store.
// Optional PEAK_DETECT_EN adds peak_bin/peak_mag tracking of the strongest non-DC stored bin.
module fft_spectrum_capture
    import fft_cap_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             source_valid,
    output logic             source_ready,
    input  logic             source_sop,
    input  logic             source_eop,
    input  logic [1:0]       source_error,
    input  logic [DW-1:0]    source_real,
    input  logic [DW-1:0]    source_imag,
    input  logic [5:0]       source_exp,
    input  logic [AW-1:0]    rd_addr,
    output logic [MAG_W-1:0] rd_data,
    input  logic             rd_lock,
    output logic             frame_valid,
    output logic [5:0]       frame_exp,
    output logic             frame_done,
    output logic             bad_frame,
`ifdef PEAK_DETECT_EN
    output logic [AW-1:0]    peak_bin,
    output logic [MAG_W-1:0] peak_mag,
`endif
    output logic [15:0]      err_cnt
);

    localparam logic [CW-1:0] LAST = CW'(FFT_LEN - 1);

    cap_state_t state_q, state_d;
    logic [CW-1:0] bin_cnt, cnt_d, idx;
    logic          taint_q, taint_d;
    logic          beat, err_nz, start, accept, bad_d, good_d;

    logic          s1_we;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_are, s1_aim;
    logic [MAG_W-1:0] wr_mag;

    logic          bank_sel, good_s1, swap, drop;
    logic [5:0]    cap_exp;
    logic [16:0]   err_sum;

    assign beat   = source_valid & source_ready;
    assign err_nz = |source_error;
    assign start  = beat & source_sop;
    assign wr_mag = l1_sum(s1_are, s1_aim);
    assign swap   = good_s1 & ~rd_lock;
    assign drop   = good_s1 & rd_lock;
    assign err_sum = {1'b0, err_cnt} + 17'(bad_d) + 17'(drop);

    always_comb begin
        state_d = state_q;
        cnt_d   = bin_cnt;
        taint_d = taint_q;
        idx     = bin_cnt;
        accept  = 1'b0;
        bad_d   = 1'b0;
        good_d  = 1'b0;
        if (beat) begin
            if (source_sop) begin
                // sop always opens bin 0; it is a restart error mid-frame, and sop&eop is never a full frame
                accept  = 1'b1;
                idx     = '0;
                taint_d = err_nz;
                cnt_d   = CW'(1);
                bad_d   = (state_q == CAPTURE) | source_eop;
                state_d = source_eop ? IDLE : CAPTURE;
            end else if (state_q == CAPTURE) begin
                accept  = 1'b1;
                cnt_d   = bin_cnt + CW'(1);
                taint_d = taint_q | err_nz;
                if (source_eop || bin_cnt == LAST) begin
                    state_d = IDLE;
                    good_d  = source_eop && (bin_cnt == LAST) && !taint_d;
                    bad_d   = !good_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bin_cnt      <= '0;
            taint_q      <= 1'b0;
            source_ready <= 1'b0;
            s1_we        <= 1'b0;
            s1_addr      <= '0;
            s1_are       <= '0;
            s1_aim       <= '0;
            good_s1      <= 1'b0;
            bank_sel     <= 1'b0;
            cap_exp      <= '0;
            frame_valid  <= 1'b0;
            frame_exp    <= '0;
            frame_done   <= 1'b0;
            bad_frame    <= 1'b0;
            err_cnt      <= '0;
        end else begin
            source_ready <= 1'b1;
            state_q      <= state_d;
            bin_cnt      <= cnt_d;
            taint_q      <= taint_d;
            s1_we        <= accept & ~idx[CW-1];
            s1_addr      <= idx[AW-1:0];
            s1_are       <= abs_u(source_real);
            s1_aim       <= abs_u(source_imag);
            if (start) begin
                cap_exp <= source_exp;
            end
            good_s1    <= good_d;
            bad_frame  <= bad_d;
            frame_done <= swap;
            // good_s1 lines up with the final RAM write, so the toggle never splits a frame
            if (swap) begin
                bank_sel    <= ~bank_sel;
                frame_valid <= 1'b1;
                frame_exp   <= cap_exp;
            end
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    spectrum_bin_ram #(
        .ADDR_W (AW + 1),
        .DATA_W (MAG_W)
    ) u_ram (
        .clk     (clk),
        .we      (s1_we),
        .wr_addr ({bank_sel, s1_addr}),
        .wr_data (wr_mag),
        .rd_addr ({~bank_sel, rd_addr}),
        .rd_data (rd_data)
    );

`ifdef PEAK_DETECT_EN
    logic [MAG_W-1:0] pk_mag_q;
    logic [AW-1:0]    pk_bin_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pk_mag_q <= '0;
            pk_bin_q <= '0;
            peak_bin <= '0;
            peak_mag <= '0;
        end else begin
            // strict compare keeps the lowest index on ties; bin 0 (DC) never competes
            if (start) begin
                pk_mag_q <= '0;
                pk_bin_q <= '0;
            end else if (s1_we && s1_addr != '0 && wr_mag > pk_mag_q) begin
                pk_mag_q <= wr_mag;
                pk_bin_q <= s1_addr;
            end
            if (swap) begin
                peak_bin <= pk_bin_q;
                peak_mag <= pk_mag_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_spectrum_capture.sv
// Self-checking bench for fft_spectrum_capture: frame-level model plus directed literal checks.
// Peak outputs are checked only when PEAK_DETECT_EN is defined.
module tb_fft_spectrum_capture;
    import fft_cap_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             source_valid = 1'b0;
    logic             source_ready;
    logic             source_sop = 1'b0;
    logic             source_eop = 1'b0;
    logic [1:0]       source_error = 2'd0;
    logic [DW-1:0]    source_real = '0;
    logic [DW-1:0]    source_imag = '0;
    logic [5:0]       source_exp = '0;
    logic [AW-1:0]    rd_addr = '0;
    logic [MAG_W-1:0] rd_data;
    logic             rd_lock = 1'b0;
    logic             frame_valid;
    logic [5:0]       frame_exp;
    logic             frame_done;
    logic             bad_frame;
    logic [15:0]      err_cnt;
`ifdef PEAK_DETECT_EN
    logic [AW-1:0]    peak_bin;
    logic [MAG_W-1:0] peak_mag;
`endif

    fft_spectrum_capture dut (
        .clk          (clk),
        .reset        (reset),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_error (source_error),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .source_exp   (source_exp),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_lock      (rd_lock),
        .frame_valid  (frame_valid),
        .frame_exp    (frame_exp),
        .frame_done   (frame_done),
        .bad_frame    (bad_frame),
`ifdef PEAK_DETECT_EN
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
`endif
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Frame-level reference model, advanced once per rising edge.
    int         cyc = 0;
    int         m_ready = 0, m_bad = 0, m_done = 0, m_valid = 0, m_err = 0;
    logic [5:0] m_exp = '0;
    int         fb [0:FFT_LEN/2-1];
    int         rb [0:FFT_LEN/2-1];
    bit         in_frame = 0, tainted = 0, pend = 0;
    int         cnt = 0;
    logic [5:0] cur_exp = '0, fexp = '0;

    function automatic int mag_of(logic [DW-1:0] re, logic [DW-1:0] im);
        int r;
        int i;
        r = $signed(re);
        i = $signed(im);
        return (r < 0 ? -r : r) + (i < 0 ? -i : i);
    endfunction

    task automatic model_step();
        bit beat;
        bit bad;
        bit done;
        int inc;
        cyc++;
        if (reset) begin
            m_ready = 0; m_bad = 0; m_done = 0; m_valid = 0; m_err = 0; m_exp = '0;
            in_frame = 0; pend = 0; cnt = 0; tainted = 0;
            return;
        end
        beat = source_valid && (m_ready != 0);
        bad = 0; done = 0; inc = 0;
        if (pend) begin
            if (rd_lock) inc++;
            else begin
                done = 1;
                for (int k = 0; k < FFT_LEN/2; k++) rb[k] = fb[k];
                m_valid = 1;
                m_exp = fexp;
            end
            pend = 0;
        end
        if (beat) begin
            if (source_sop) begin
                if (in_frame) bad = 1;
                in_frame = 1;
                cnt = 0;
                tainted = (source_error != 0);
                cur_exp = source_exp;
            end else if (in_frame) begin
                tainted = tainted || (source_error != 0);
            end
            if (in_frame) begin
                if (cnt < FFT_LEN/2) fb[cnt] = mag_of(source_real, source_imag);
                cnt++;
                if (source_eop) begin
                    if (cnt == FFT_LEN && !tainted) begin pend = 1; fexp = cur_exp; end
                    else bad = 1;
                    in_frame = 0;
                end else if (cnt == FFT_LEN) begin
                    bad = 1;
                    in_frame = 0;
                end
            end
        end
        if (bad) inc++;
        m_bad = bad;
        m_done = done;
        m_err = (m_err + inc > 65535) ? 65535 : m_err + inc;
        m_ready = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int done_cnt = 0, bad_cnt = 0, done_cyc = 0, eop_cyc = 0;

    task automatic compare_all();
        chk("source_ready", 64'(source_ready), 64'(m_ready));
        chk("bad_frame", 64'(bad_frame), 64'(m_bad));
        chk("frame_done", 64'(frame_done), 64'(m_done));
        chk("frame_valid", 64'(frame_valid), 64'(m_valid));
        chk("frame_exp", 64'(frame_exp), 64'(m_exp));
        chk("err_cnt", 64'(err_cnt), 64'(m_err));
        if (frame_done === 1'b1) begin done_cnt++; done_cyc = cyc + 1; end
        if (bad_frame === 1'b1) bad_cnt++;
    endtask

    // Every wait goes through here: compare on the falling edge, resume just after the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [DW-1:0] re_of(int pat, int k);
        case (pat)
            1:       return (k == 5) ? 24'h800000 : DW'(k);
            2:       return DW'(7);
            3:       return (k == 0) ? DW'(5000) : '0;
            default: return DW'(k);
        endcase
    endfunction

    function automatic logic [DW-1:0] im_of(int pat, int k);
        case (pat)
            1:       return (k == 5) ? 24'h800000 : DW'(-k);
            2:       return DW'(k);
            3:       return (k == 300) ? DW'(-1000) : '0;
            default: return DW'(-k);
        endcase
    endfunction

    task automatic send_frame(int n, int eop_at, int pat, logic [5:0] ex, int err_at);
        for (int k = 0; k < n; k++) begin
            source_valid = 1'b1;
            source_sop   = (k == 0);
            source_eop   = (k == eop_at);
            source_error = (k == err_at) ? 2'd1 : 2'd0;
            source_real  = re_of(pat, k);
            source_imag  = im_of(pat, k);
            source_exp   = ex;
            if (k == eop_at) eop_cyc = cyc + 1;
            tick();
        end
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        source_error = 2'd0;
    endtask

    task automatic read_model(int k);
        rd_addr = AW'(k);
        tick();
        chk("rd_data_model", 64'(rd_data), 64'(rb[k]));
    endtask

    task automatic read_lit(int k, int expv);
        rd_addr = AW'(k);
        tick();
        chk("rd_data_lit", 64'(rd_data), 64'(expv));
    endtask

    int done_before;

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_ready", 64'(source_ready), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        reset = 1'b0;
        idle(2);
        chk("ready_after_reset", 64'(source_ready), 64'd1);

        // early eop at beat 100
        send_frame(101, 100, 0, 6'd1, -1);
        idle(3);
        chk("t3_err_cnt", 64'(err_cnt), 64'd1);
        chk("t3_bad_pulses", 64'(bad_cnt), 64'd1);
        chk("t3_frame_valid", 64'(frame_valid), 64'd0);

        // good frame: re=k, im=-k, exp=-3
        send_frame(FFT_LEN, FFT_LEN-1, 0, 6'h3D, -1);
        idle(4);
        chk("t1_done_latency", 64'(done_cyc - eop_cyc), 64'd2);
        chk("t1_frame_valid", 64'(frame_valid), 64'd1);
        chk("t1_frame_exp", 64'(frame_exp), 64'h3D);
        chk("t1_err_cnt", 64'(err_cnt), 64'd1);
        for (int k = 0; k < FFT_LEN/2; k++) read_model(k);
        read_lit(0, 0);
        read_lit(5, 10);
        read_lit(2047, 4094);

        // most-negative real and imag on bin 5
        send_frame(FFT_LEN, FFT_LEN-1, 1, 6'd5, -1);
        idle(4);
        read_lit(5, 32'h0100_0000);
        read_lit(4, 8);
        read_lit(6, 12);
        chk("t2_frame_exp", 64'(frame_exp), 64'd5);

        // restart on sop at beat 2000, then a full frame from that sop
        send_frame(2000, -1, 0, 6'd7, -1);
        send_frame(FFT_LEN, FFT_LEN-1, 0, 6'd9, -1);
        idle(4);
        chk("t4_err_cnt", 64'(err_cnt), 64'd2);
        chk("t4_frame_exp", 64'(frame_exp), 64'd9);
        for (int k = 0; k < 16; k++) read_model(k);

        // single beat carrying sop and eop
        send_frame(1, 0, 0, 6'd11, -1);
        idle(3);
        chk("sop_eop_err_cnt", 64'(err_cnt), 64'd3);

        // full-length frame tainted by source_error on beat 10
        send_frame(FFT_LEN, FFT_LEN-1, 2, 6'd12, 10);
        idle(3);
        chk("taint_err_cnt", 64'(err_cnt), 64'd4);
        chk("taint_frame_exp", 64'(frame_exp), 64'd9);

        // good frame finishing under rd_lock is dropped
        done_before = done_cnt;
        rd_lock = 1'b1;
        send_frame(FFT_LEN, FFT_LEN-1, 2, 6'd13, -1);
        idle(4);
        rd_lock = 1'b0;
        idle(2);
        chk("t5_no_done", 64'(done_cnt), 64'(done_before));
        chk("t5_err_cnt", 64'(err_cnt), 64'd5);
        chk("t5_frame_exp", 64'(frame_exp), 64'd9);
        read_lit(10, 20);
        for (int k = 2040; k < 2048; k++) read_model(k);

        // reset mid-frame, then one full tone frame
        send_frame(1500, -1, 0, 6'd14, -1);
        reset = 1'b1;
        done_cnt = 0;
        bad_cnt = 0;
        idle(2);
        reset = 1'b0;
        idle(2);
        send_frame(FFT_LEN, FFT_LEN-1, 3, 6'd2, -1);
        idle(4);
        chk("t6_done_count", 64'(done_cnt), 64'd1);
        chk("t6_bad_count", 64'(bad_cnt), 64'd0);
        chk("t6_err_cnt", 64'(err_cnt), 64'd0);
        chk("t6_frame_exp", 64'(frame_exp), 64'd2);
        read_lit(300, 1000);
        read_lit(0, 5000);
        read_lit(301, 0);
`ifdef PEAK_DETECT_EN
        chk("peak_bin", 64'(peak_bin), 64'd300);
        chk("peak_mag", 64'(peak_mag), 64'd1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
